mmm_nlp_red_90b: RTL and testbench

- Consumer end of the 90-bit NLP Montgomery multiplier: takes the 181-bit product T from the multiplier stage and returns T*R^-1 mod M, with R = 2^96.
- Word-serial reduction: one 16-bit digit per cycle, 6 iterations, under a valid/ready handshake on both sides.
- Output is non-least-positive (NLP): the result is < 2M, so it can feed the next multiplication directly without a final subtraction.

---
 rtl/mmm_nlp_pkg.sv | 19 +
 rtl/mmm_nlp_red_step.sv | 30 +++
 rtl/mmm_nlp_red_90b.sv | 120 ++++++++++++
 tb/tb_mmm_nlp_red_90b.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmm_nlp_pkg.sv
// Shared widths and FSM state encoding for the 90-bit NLP
// Montgomery reduction stage.
package mmm_nlp_pkg;

  localparam int IDW = 90;
  localparam int ODW = 181;
  localparam int WW  = 16;
  localparam int NW  = 6;
  localparam int ACW = ODW + 1;
  localparam int CW  = 3;

  typedef enum logic [1:0] {
    IDLE,
    RED,
    SUB,
    DONE
  } state_t;

endpackage

// File: rtl/mmm_nlp_red_step.sv
// One word-serial Montgomery iteration:
// q = acc*m' mod 2^16, next = (acc + q*M) >> 16.
module mmm_nlp_red_step
  import mmm_nlp_pkg::*;
(
  input  logic [ACW-1:0] acc,
  input  logic [IDW-1:0] m,
  input  logic [WW-1:0]  mp,
  output logic [ACW-1:0] nxt,
  output logic           low_zero
);

  localparam int PW = IDW + WW;
  localparam int SW = ACW + WW;

  logic [WW-1:0] q;
  logic [PW-1:0] qm;
  logic [SW-1:0] sum;

  // digit quotient, multiple of M, and the widened sum
  always_comb begin
    q   = acc[WW-1:0] * mp;
    qm  = PW'(q) * PW'(m);
    sum = SW'(acc) + SW'(qm);
  end

  assign nxt      = sum[SW-1:WW];
  assign low_zero = (sum[WW-1:0] == '0);

endmodule

// File: rtl/mmm_nlp_red_90b.sv
// Montgomery reduction T*2^-96 mod M, NLP result (< 2M).
// MMM_NLP_RED_FINAL_SUB_EN adds a final subtract (result < M).
module mmm_nlp_red_90b
  import mmm_nlp_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic [ODW-1:0] i_t,
  input  logic [IDW-1:0] i_m,
  input  logic [WW-1:0]  i_mp,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [IDW:0]   o_res
);

  state_t         state;
  logic [ACW-1:0] acc;
  logic [ACW-1:0] nxt;
  logic [IDW-1:0] m_q;
  logic [WW-1:0]  mp_q;
  logic [CW-1:0]  cnt;
  logic           low_zero;

  mmm_nlp_red_step u_step (
    .acc      (acc),
    .m        (m_q),
    .mp       (mp_q),
    .nxt      (nxt),
    .low_zero (low_zero)
  );

`ifdef MMM_NLP_RED_FINAL_SUB_EN
  logic [ACW:0] diff;
  logic         borrow;

  // trial subtraction of M from the NLP result
  always_comb begin
    diff   = {1'b0, acc} - (ACW+1)'(m_q);
    borrow = diff[ACW];
  end
`endif

  // handshake FSM, iteration counter and operand capture
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      m_q     <= '0;
      mp_q    <= '0;
      o_valid <= 1'b0;
      o_ready <= 1'b0;
      o_res   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          o_ready <= 1'b1;
          if (i_valid && o_ready) begin
            acc     <= ACW'(i_t);
            m_q     <= i_m;
            mp_q    <= i_mp;
            cnt     <= '0;
            o_ready <= 1'b0;
            state   <= RED;
          end
        end
        RED: begin
          acc <= nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(NW-1)) begin
`ifdef MMM_NLP_RED_FINAL_SUB_EN
            state   <= SUB;
`else
            state   <= DONE;
            o_valid <= 1'b1;
            o_res   <= nxt[IDW:0];
`endif
          end
        end
`ifdef MMM_NLP_RED_FINAL_SUB_EN
        SUB: begin
          state   <= DONE;
          o_valid <= 1'b1;
          if (!borrow) begin
            acc   <= diff[ACW-1:0];
            o_res <= diff[IDW:0];
          end else begin
            o_res <= acc[IDW:0];
          end
        end
`endif
        DONE: begin
          if (i_ready) begin
            state   <= IDLE;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          o_valid <= 1'b0;
          o_ready <= 1'b0;
        end
      endcase
    end
  end

  // each step clears the low digit; the final value fits IDW+1 bits
  always_ff @(posedge i_clk) begin
    if (!i_rst && state == RED) begin
      assert (low_zero);
    end
    if (!i_rst && state == DONE) begin
      assert (acc[ACW-1:IDW+1] == '0);
    end
  end

endmodule

// File: tb/tb_mmm_nlp_red_90b.sv
// Directed and random checks for mmm_nlp_red_90b.
// Expected values are hand-derived or from modular identities.
module tb_mmm_nlp_red_90b;
  import mmm_nlp_pkg::*;

`ifdef MMM_NLP_RED_FINAL_SUB_EN
  localparam int LAT = NW + 2;
  localparam int GAP = NW + 3;
  localparam logic [IDW:0] EXP_B = 91'd0;
`else
  localparam int LAT = NW + 1;
  localparam int GAP = NW + 2;
  localparam logic [IDW:0] EXP_B = 91'd3;
`endif

  logic           clk;
  logic           rst;
  logic           i_valid;
  logic           o_ready;
  logic [ODW-1:0] i_t;
  logic [IDW-1:0] i_m;
  logic [WW-1:0]  i_mp;
  logic           o_valid;
  logic           i_ready;
  logic [IDW:0]   o_res;

  int checks = 0;
  int errors = 0;

  logic [ODW-1:0] t_b;
  logic [ODW-1:0] t_one;

  mmm_nlp_red_90b dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_t     (i_t),
    .i_m     (i_m),
    .i_mp    (i_mp),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_res   (o_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!o_ready && k < 30) begin
      tick();
      k++;
    end
  endtask

  task automatic do_op(input logic [ODW-1:0] t,
                       input logic [IDW-1:0] m,
                       input logic [WW-1:0] mp,
                       output logic [IDW:0] res,
                       output int lat);
    wait_ready();
    i_t = t;
    i_m = m;
    i_mp = mp;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    i_t = '1;
    i_m = '0;
    i_mp = '0;
    lat = 1;
    while (!o_valid && lat < 50) begin
      tick();
      lat++;
    end
    res = o_res;
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid got %0b want 0", o_valid);
    end
    checks++;
    if (o_res !== '0) begin
      errors++;
      $display("FAIL rst_res got %0h want 0", o_res);
    end
    checks++;
    if (o_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_ready got %0b want 0", o_ready);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready_after got %0b want 1", o_ready);
    end
  endtask

  task automatic test_identity();
    logic [IDW:0] r;
    int lat;
    do_op(t_one, 90'd3, 16'h5555, r, lat);
    checks++;
    if (r !== 91'd1) begin
      errors++;
      $display("FAIL ident_t1 got %0h want 1", r);
    end
    checks++;
    if (lat != LAT) begin
      errors++;
      $display("FAIL ident_t1_lat got %0d want %0d", lat, LAT);
    end
    do_op('0, 90'd3, 16'h5555, r, lat);
    checks++;
    if (r !== 91'd0) begin
      errors++;
      $display("FAIL ident_t0 got %0h want 0", r);
    end
    checks++;
    if (lat != LAT) begin
      errors++;
      $display("FAIL ident_t0_lat got %0d want %0d", lat, LAT);
    end
  endtask

  task automatic test_nlp_boundary();
    logic [IDW:0] r;
    int lat;
    do_op(t_b, 90'd3, 16'h5555, r, lat);
    checks++;
    if (r !== EXP_B) begin
      errors++;
      $display("FAIL nlp_bound got %0h want %0h", r, EXP_B);
    end
  endtask

  task automatic test_backpressure();
    int k;
    wait_ready();
    i_t = t_b;
    i_m = 90'd3;
    i_mp = 16'h5555;
    i_valid = 1'b1;
    tick();
    i_t = t_one;
    tick();
    tick();
    i_valid = 1'b0;
    k = 0;
    while (!o_valid && k < 50) begin
      tick();
      k++;
    end
    i_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (o_valid !== 1'b1 || o_res !== EXP_B || o_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got v=%0b r=%0h rdy=%0b want v=1 r=%0h rdy=0",
                 i, o_valid, o_res, o_ready, EXP_B);
      end
      tick();
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_retire got v=%0b rdy=%0b want v=0 rdy=1",
               o_valid, o_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [ODW-1:0] vt [2];
    logic [IDW:0]   want [2];
    logic [IDW:0]   got [2];
    int acc_cyc [2];
    int nacc = 0;
    int nres = 0;
    int v = 0;
    logic acc_now;
    logic ret_now;
    logic [IDW:0] cap;
    vt[0] = t_b;
    vt[1] = t_one;
    want[0] = EXP_B;
    want[1] = 91'd1;
    acc_cyc[0] = 0;
    acc_cyc[1] = 0;
    got[0] = '1;
    got[1] = '1;
    wait_ready();
    i_m = 90'd3;
    i_mp = 16'h5555;
    i_t = vt[0];
    i_valid = 1'b1;
    i_ready = 1'b1;
    for (int c = 0; c < 40 && nres < 2; c++) begin
      acc_now = o_ready && i_valid;
      ret_now = o_valid;
      cap = o_res;
      tick();
      if (acc_now) begin
        acc_cyc[nacc] = c;
        nacc++;
        v++;
        if (v < 2) i_t = vt[v];
        else i_valid = 1'b0;
      end
      if (ret_now) begin
        got[nres] = cap;
        nres++;
      end
    end
    i_valid = 1'b0;
    i_ready = 1'b0;
    checks++;
    if (nacc != 2 || nres != 2) begin
      errors++;
      $display("FAIL b2b_count got acc=%0d res=%0d want 2 2", nacc, nres);
    end
    checks++;
    if (acc_cyc[1] - acc_cyc[0] != GAP) begin
      errors++;
      $display("FAIL b2b_gap got %0d want %0d", acc_cyc[1] - acc_cyc[0], GAP);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (got[i] !== want[i]) begin
        errors++;
        $display("FAIL b2b_res%0d got %0h want %0h", i, got[i], want[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [IDW:0] r;
    int lat;
    int seen;
    wait_ready();
    i_t = t_b;
    i_m = 90'd3;
    i_mp = 16'h5555;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (o_valid !== 1'b0 || o_res !== '0 || o_ready !== 1'b0) begin
      errors++;
      $display("FAIL rmid_state got v=%0b r=%0h rdy=%0b want 0 0 0",
               o_valid, o_res, o_ready);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (o_valid) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rmid_no_out got %0d valid cycles want 0", seen);
    end
    do_op(t_one, 90'd3, 16'h5555, r, lat);
    checks++;
    if (r !== 91'd1) begin
      errors++;
      $display("FAIL rmid_fresh got %0h want 1", r);
    end
  endtask

  task automatic test_random();
    logic [88:0]    m89;
    logic [IDW-1:0] m;
    logic [IDW:0]   m2;
    logic [95:0]    r96;
    logic [IDW:0]   a;
    logic [IDW:0]   b;
    logic [ODW-1:0] t;
    logic [15:0]    x;
    logic [15:0]    m16;
    logic [IDW:0]   r;
    logic [191:0]   lhs;
    logic [191:0]   rhs;
    logic [IDW:0]   lim;
    int lat;
    for (int n = 0; n < 1000; n++) begin
      m89 = 89'({$urandom, $urandom, $urandom});
      m89[0] = 1'b1;
      m89[88] = 1'b1;
      m = {1'b0, m89};
      m2 = {m, 1'b0};
      r96 = {$urandom, $urandom, $urandom};
      a = 91'(r96 % 96'(m2));
      r96 = {$urandom, $urandom, $urandom};
      b = 91'(r96 % 96'(m2));
      t = ODW'(a) * ODW'(b);
      m16 = m[15:0];
      x = m16;
      repeat (4) x = x * (16'd2 - m16 * x);
      do_op(t, m, -x, r, lat);
      lhs = (192'(r) << 96) % 192'(m);
      rhs = 192'(t) % 192'(m);
      checks++;
      if (lhs !== rhs) begin
        errors++;
        $display("FAIL rnd_cong%0d got %0h want res*R=T mod %0h", n, r, m);
      end
`ifdef MMM_NLP_RED_FINAL_SUB_EN
      lim = {1'b0, m};
`else
      lim = m2;
`endif
      checks++;
      if (!(r < lim)) begin
        errors++;
        $display("FAIL rnd_range%0d got %0h want below %0h", n, r, lim);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_t = '0;
    i_m = '0;
    i_mp = '0;
    t_one = '0;
    t_one[0] = 1'b1;
    t_b = '0;
    t_b[97] = 1'b1;
    t_b[0] = 1'b1;
    #1;
    test_reset();
    test_identity();
    test_nlp_boundary();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
